// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between port A (core MEM
// stage) and port B (loader / debug). One outstanding access at a time,
// fixed memory latency MEM_LAT, registered outputs only.
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking;
// otherwise port A has fixed priority on ties.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic [3:0]        a_be,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  input  logic [3:0]        b_be,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic              a_err,
  output logic              b_err,
  output logic [31:0]       rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_be,
  input  logic [31:0]       m_rdata
);

  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic               cur_b;
  logic               cur_we;
`ifdef DMEM_ARB_RR_EN
  logic               last_grant;
`endif

  logic               pick_b;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_be;
  logic               sel_ok;

  // Legal size/offset combinations for an access.
  function automatic logic is_aligned(input logic we, input logic [1:0] lo,
                                      input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    if (!we) begin
      ok = (lo == 2'b00);
    end else begin
      unique case (be)
        4'b1111:                         ok = (lo == 2'b00);
        4'b0011, 4'b1100:                ok = !lo[0];
        4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
        default:                         ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Winner selection and mux of the winner's request fields.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    pick_b = b_req && (!a_req || !last_grant);
`else
    pick_b = b_req && !a_req;
`endif
    sel_we    = pick_b ? b_we    : a_we;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    sel_be    = pick_b ? b_be    : a_be;
    sel_ok    = is_aligned(sel_we, sel_addr[1:0], sel_be);
  end

  // Transaction FSM; strobes are set on entry to the state that owns them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      cur_b    <= 1'b0;
      cur_we   <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      rdata    <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (a_req || b_req) begin
            cur_b  <= pick_b;
            cur_we <= sel_we;
            a_gnt  <= !pick_b;
            b_gnt  <= pick_b;
`ifdef DMEM_ARB_RR_EN
            last_grant <= pick_b;
`endif
            if (sel_ok) begin
              m_req   <= 1'b1;
              m_we    <= sel_we;
              m_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
              m_wdata <= sel_wdata;
              m_be    <= sel_be;
              state   <= S_ISSUE;
            end else begin
              // Misaligned: answer immediately, memory is never touched.
              a_rvalid <= !pick_b;
              b_rvalid <= pick_b;
              a_err    <= !pick_b;
              b_err    <= pick_b;
              rdata    <= '0;
              state    <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          lat_cnt <= LAT_W'(MEM_LAT - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            rdata    <= cur_we ? 32'd0 : m_rdata;
            a_rvalid <= !cur_b;
            b_rvalid <= cur_b;
            state    <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter (MEM_LAT=4). Expected tie order follows the
// DMEM_ARB_RR_EN build option.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LAT    = 4;

  logic clock, reset;
  logic a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr, m_addr;
  logic [31:0] a_wdata, b_wdata, rdata, m_wdata, m_rdata;
  logic [3:0] a_be, b_be, m_be;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, m_req, m_we;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_err(a_err), .b_err(b_err), .rdata(rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic err; logic [31:0] rdata; } exp_t;
  typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [31:0] wdata; logic [3:0] be; } mx_t;

  exp_t exp_a[$], exp_b[$];
  mx_t  mq_a[$], mq_b[$];
  logic gq[$];
  logic [31:0] ref_mem [1024];
  int checks = 0;
  int failures = 0;

  // Memory macro model: writes at the strobe edge, read data after LAT cycles.
  logic [31:0] mem  [1024];
  logic [31:0] pipe [LAT];
  always @(posedge clock) begin
    if (m_req && m_we)
      for (int i = 0; i < 4; i++)
        if (m_be[i]) mem[m_addr[11:2]][8*i +: 8] <= m_wdata[8*i +: 8];
    pipe[0] <= (m_req && !m_we) ? mem[m_addr[11:2]] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign m_rdata = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ok_align(input logic we, input logic [1:0] lo, input logic [3:0] be);
    if (!we) return lo == 2'b00;
    case (be)
      4'hF:                return lo == 2'b00;
      4'h3, 4'hC:          return !lo[0];
      4'h1, 4'h2, 4'h4, 4'h8: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  exp_t mon_e;
  mx_t  mon_m;
  // Scoreboard monitor: memory strobes and responses checked mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      if (a_gnt || b_gnt) begin
        gq.push_back(b_gnt);
        chk("gnt_onehot", 32'(a_gnt & b_gnt), 32'd0);
        if (m_req) begin
          if ((b_gnt ? mq_b.size() : mq_a.size()) == 0) chk("mreq_unexpected", 32'(m_req), 32'd0);
          else begin
            mon_m = b_gnt ? mq_b.pop_front() : mq_a.pop_front();
            chk("m_we", 32'(m_we), 32'(mon_m.we));
            chk("m_addr", 32'(m_addr), 32'(mon_m.addr));
            if (mon_m.we) begin
              chk("m_be", 32'(m_be), 32'(mon_m.be));
              chk("m_wdata", m_wdata, mon_m.wdata);
            end
          end
        end
      end else if (m_req) chk("mreq_without_gnt", 32'(m_req), 32'd0);
      if (a_rvalid) begin
        if (exp_a.size() == 0) chk("a_rvalid_unexpected", 32'(a_rvalid), 32'd0);
        else begin
          mon_e = exp_a.pop_front();
          chk("a_err", 32'(a_err), 32'(mon_e.err));
          chk("a_rdata", rdata, mon_e.rdata);
        end
      end
      if (b_rvalid) begin
        if (exp_b.size() == 0) chk("b_rvalid_unexpected", 32'(b_rvalid), 32'd0);
        else begin
          mon_e = exp_b.pop_front();
          chk("b_err", 32'(b_err), 32'(mon_e.err));
          chk("b_rdata", rdata, mon_e.rdata);
        end
      end
    end
  end

  // One transaction on a port: push expectations, request, follow to rvalid.
  task automatic txn(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input bit solo);
    logic al, got, rv;
    exp_t e;
    mx_t  mx;
    int n, m;
    al = ok_align(we, addr[1:0], be);
    e.err   = !al;
    e.rdata = (!al || we) ? 32'd0 : ref_mem[addr[11:2]];
    if (al && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[addr[11:2]][8*i +: 8] = wdata[8*i +: 8];
    mx.we = we; mx.addr = {addr[11:2], 2'b00}; mx.wdata = wdata; mx.be = be;
    if (port) begin exp_b.push_back(e); if (al) mq_b.push_back(mx); end
    else      begin exp_a.push_back(e); if (al) mq_a.push_back(mx); end
    @(negedge clock);
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be; end
    n = 0; got = 0;
    while (n < 60 && !got) begin
      @(negedge clock); n++;
      got = port ? b_gnt : a_gnt;
    end
    if (port) b_req = 0; else a_req = 0;
    if (!got) begin chk("gnt_timeout", 32'(got), 32'd1); return; end
    if (solo) chk("gnt_latency", 32'(n), 32'd1);
    m = 0;
    rv = port ? b_rvalid : a_rvalid;
    while (!rv && m < 60) begin
      @(negedge clock); m++;
      rv = port ? b_rvalid : a_rvalid;
    end
    chk("rvalid_latency", 32'(m), al ? 32'(LAT + 1) : 32'd0);
    if (solo) chk("sample_to_rvalid", 32'(n + m), al ? 32'(LAT + 2) : 32'd1);
  endtask

  logic [3:0] exp_order;
  int n;

  initial begin
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    reset = 1;
    #2 reset = 0;
    repeat (3) @(negedge clock);
    chk("por_ctl", {24'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, m_req, m_we}, 32'd0);
    chk("por_rdata", rdata, 32'd0);
    chk("por_maddr", 32'(m_addr), 32'd0);
    reset = 1;
    @(negedge clock);

    // Word write/read, byte merge, half-word and byte lanes
    txn(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 1);
    txn(0, 0, 12'h010, 32'h0, 4'h0, 1);
    txn(1, 1, 12'h013, 32'hAB000000, 4'b1000, 1);
    txn(0, 0, 12'h010, 32'h0, 4'h0, 1);
    txn(1, 1, 12'h020, 32'h11223344, 4'hF, 1);
    txn(1, 1, 12'h022, 32'h55660000, 4'b1100, 1);
    txn(1, 1, 12'h021, 32'h00007700, 4'b0010, 1);
    txn(1, 0, 12'h020, 32'h0, 4'h0, 1);

    // Misaligned cases: immediate error, no memory strobe
    txn(0, 0, 12'h006, 32'h0, 4'h0, 1);
    txn(1, 1, 12'h021, 32'h12345678, 4'b0011, 1);
    txn(1, 1, 12'h020, 32'h12345678, 4'b0101, 1);
    txn(0, 1, 12'h012, 32'h12345678, 4'hF, 1);
    txn(0, 0, 12'h010, 32'h0, 4'h0, 1);

    // Tie: both ports keep requesting for two accesses each
    gq.delete();
    fork
      begin txn(0, 1, 12'h040, 32'hA0A0A0A0, 4'hF, 0); txn(0, 0, 12'h040, 32'h0, 4'h0, 0); end
      begin txn(1, 1, 12'h080, 32'hB1B1B1B1, 4'hF, 0); txn(1, 0, 12'h080, 32'h0, 4'h0, 0); end
    join
`ifdef DMEM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1100;
`endif
    chk("tie_count", 32'(gq.size()), 32'd4);
    if (gq.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), 32'(gq[i]), 32'(exp_order[i]));

    // Reset asserted while the access is waiting on memory
    mq_a.push_back('{we: 1'b0, addr: 12'h010, wdata: 32'h0, be: 4'h0});
    exp_a.push_back('{err: 1'b0, rdata: 32'h0});
    @(negedge clock);
    a_req = 1; a_we = 0; a_addr = 12'h010; a_wdata = 32'hCAFEF00D; a_be = 4'hF;
    n = 0;
    while (n < 60 && !a_gnt) begin @(negedge clock); n++; end
    a_req = 0;
    chk("rst_gnt_seen", 32'(a_gnt), 32'd1);
    repeat (2) @(negedge clock);
    reset = 0;
    #1;
    chk("rst_ctl", {24'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, m_req, m_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_maddr", 32'(m_addr), 32'd0);
    chk("rst_mwdata", m_wdata, 32'd0);
    chk("rst_mbe", 32'(m_be), 32'd0);
    exp_a.delete(); mq_a.delete();
    repeat (2) @(negedge clock);
    reset = 1;
    repeat (12) @(negedge clock);
    txn(0, 0, 12'h010, 32'h0, 4'h0, 1);
    repeat (4) @(negedge clock);

    chk("exp_a_left", 32'(exp_a.size()), 32'd0);
    chk("exp_b_left", 32'(exp_b.size()), 32'd0);
    chk("mq_a_left", 32'(mq_a.size()), 32'd0);
    chk("mq_b_left", 32'(mq_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
